dpram_stream_reader: RTL

- Read-side engine for a dual-port block RAM port with 1-cycle registered read latency. On a start pulse, it reads a contiguous address range and emits the words as a valid/ready stream.
- Absorbs the RAM read latency and downstream backpressure with an internal 4-entry FIFO.
- Sits between a dpram port (wren tied low by the integrator) and any streaming consumer, such as a video or audio fetcher.

---
 rtl/dpram_stream_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dpram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_stream_reader
//  Description : Read-side engine for a dual-port RAM port whose read data
//                arrives one cycle after the address edge. A start pulse
//                reads a contiguous, wrapping address range. The words are
//                then emitted as a valid/ready stream through a 4-entry FIFO.
//                The FIFO absorbs both the RAM latency and downstream stalls.
//  Ports       : clock, reset_n       - clock, synchronous active-low reset
//                start, start_addr,
//                length               - transfer request (sampled when idle)
//                busy, done           - transfer status
//                mem_addr, mem_q      - RAM read port
//                out_data, out_valid,
//                out_ready, out_last  - output stream
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     issue_rem_q, issue_rem_d;
  logic [ADDR_W:0]     emit_rem_q, emit_rem_d;
  logic                inflight_q, inflight_d;
  logic [DATA_W-1:0]   fifo_q [4];
  logic [DATA_W-1:0]   fifo_d [4];
  logic [1:0]          wr_idx_q, wr_idx_d;
  logic [1:0]          rd_idx_q, rd_idx_d;
  logic [2:0]          count_q, count_d;

  logic                issue;
  logic                push;
  logic                pop;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    issue_rem_d = issue_rem_q;
    emit_rem_d  = emit_rem_q;
    fifo_d      = fifo_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    count_d     = count_q;

    // A read in flight already owns a FIFO slot, so counting it here is
    // what guarantees the FIFO can never overflow.
    issue = (state_q == S_RUN) && (issue_rem_q != '0) &&
            (({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4);
    push  = inflight_q;
    pop   = (count_q != 3'd0) && out_ready;

    inflight_d = issue;

    if (issue) begin
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      issue_rem_d = issue_rem_q - (ADDR_W + 1)'(1);
    end

    if (push) begin
      fifo_d[wr_idx_q] = mem_q;
      wr_idx_d         = wr_idx_q + 2'd1;
    end

    if (pop) begin
      rd_idx_d   = rd_idx_q + 2'd1;
      emit_rem_d = emit_rem_q - (ADDR_W + 1)'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d    = start_addr;
          issue_rem_d = length;
          emit_rem_d  = length;
          state_d     = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pop && (emit_rem_q == (ADDR_W + 1)'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      issue_rem_q <= '0;
      emit_rem_q  <= '0;
      inflight_q  <= 1'b0;
      wr_idx_q    <= 2'd0;
      rd_idx_q    <= 2'd0;
      count_q     <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      issue_rem_q <= issue_rem_d;
      emit_rem_q  <= emit_rem_d;
      inflight_q  <= inflight_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign mem_addr  = rd_ptr_q;
  assign out_data  = fifo_q[rd_idx_q];
  assign out_valid = (count_q != 3'd0);
  assign out_last  = out_valid && (emit_rem_q == (ADDR_W + 1)'(1));

endmodule
`default_nettype wire
